// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the multicycle ALU sequencer: opcodes, field positions, FSM states.
package alu_sequencer_pkg;

    localparam int unsigned DATA_BUS_WIDTH = 16;

    // Instruction field positions within the 16-bit instruction register
    localparam int unsigned OPCODE_MSB = 15;
    localparam int unsigned OPCODE_LSB = 12;
    localparam int unsigned RD_MSB     = 11;
    localparam int unsigned RD_LSB     = 8;
    localparam int unsigned RS_MSB     = 7;
    localparam int unsigned RS_LSB     = 4;
    localparam int unsigned RT_MSB     = 3;
    localparam int unsigned RT_LSB     = 0;

    localparam logic [3:0] INSTR_ADD   = 4'h0;
    localparam logic [3:0] INSTR_ADDI  = 4'h1;
    localparam logic [3:0] INSTR_SUB   = 4'h2;
    localparam logic [3:0] INSTR_AND   = 4'h3;
    localparam logic [3:0] INSTR_OR    = 4'h4;
    localparam logic [3:0] INSTR_XOR   = 4'h5;
    localparam logic [3:0] INSTR_BGEQ  = 4'h6;
    localparam logic [3:0] INSTR_BLEQ  = 4'h7;
    localparam logic [3:0] INSTR_BGT   = 4'h8;
    localparam logic [3:0] INSTR_BLT   = 4'h9;
    localparam logic [3:0] INSTR_BEQ   = 4'hA;
    localparam logic [3:0] INSTR_LOAD  = 4'hB;
    localparam logic [3:0] INSTR_STORE = 4'hC;
    localparam logic [3:0] INSTR_JUMP  = 4'hD;
    localparam logic [3:0] INSTR_NOP   = 4'hE;
    localparam logic [3:0] INSTR_HALT  = 4'hF;

    typedef enum logic [3:0] {
        STATE_FETCH  = 4'd0,
        STATE_DECODE = 4'd1,
        STATE_EXEC   = 4'd2,
        STATE_AWAIT  = 4'd3,
        STATE_WB     = 4'd4,
        STATE_BRANCH = 4'd5,
        STATE_JUMP   = 4'd6,
        STATE_MEM    = 4'd7,
        STATE_WBMEM  = 4'd8,
        STATE_RETIRE = 4'd9,
        STATE_HALTED = 4'd10,
        STATE_FAULT  = 4'd11
    } state_e;

    function automatic logic is_compare(input logic [3:0] op);
        return (op >= INSTR_BGEQ) && (op <= INSTR_BEQ);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] op);
        return (op == INSTR_LOAD) || (op == INSTR_STORE);
    endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Control/status bundle between the sequencer (master) and the datapath/memory side (slave).
interface alu_sequencer_if #(
    parameter int unsigned INSTR_WIDTH      = 16,
    parameter int unsigned RETIRE_CNT_WIDTH = 16
);
    logic [INSTR_WIDTH-1:0]      instr;
    logic                        mem_rdata_valid;
    logic                        mem_ready;
    logic                        alu_flag;
    logic [3:0]                  alu_control;
    logic                        alu_src_b;
    logic                        ir_write;
    logic                        pc_write;
    logic                        pc_src;
    logic                        mem_read;
    logic                        mem_write;
    logic                        reg_write;
    logic                        wb_src;
    logic                        halted;
    logic                        fault;
    logic [RETIRE_CNT_WIDTH-1:0] retired;

    modport master (
        input  instr, mem_rdata_valid, mem_ready, alu_flag,
        output alu_control, alu_src_b, ir_write, pc_write, pc_src, mem_read, mem_write,
               reg_write, wb_src, halted, fault, retired
    );

    modport slave (
        output instr, mem_rdata_valid, mem_ready, alu_flag,
        input  alu_control, alu_src_b, ir_write, pc_write, pc_src, mem_read, mem_write,
               reg_write, wb_src, halted, fault, retired
    );

endinterface

// File: rtl/alu_sequencer_mem_wait_timer.sv
// Memory handshake wait counter; flags expiry when the limit is hit with no ready.
module alu_sequencer_mem_wait_timer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic ready_i,
    output logic expired_o
);
    localparam int unsigned CntWidth = $clog2(MEM_TIMEOUT + 1);

    logic [CntWidth-1:0] cnt_q, cnt_d;

    // Count idle handshake cycles, saturating at the limit
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (!ready_i && (cnt_q != CntWidth'(MEM_TIMEOUT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = !clr_i && !ready_i && (cnt_q == CntWidth'(MEM_TIMEOUT));

endmodule

// File: rtl/alu_sequencer.sv
// Multicycle control FSM: sequences fetch, decode, ALU, memory and writeback per instruction.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH      = 16,
    parameter int unsigned MEM_TIMEOUT      = 15,
    parameter int unsigned RETIRE_CNT_WIDTH = 16
) (
    input logic             clk,
    input logic             rst_n,
    alu_sequencer_if.master bus
);
    state_e                      state_q, state_d;
    logic [RETIRE_CNT_WIDTH-1:0] retired_q, retired_d;
    logic [INSTR_WIDTH-1:0]      instr_w;
    logic [3:0]                  opcode;
    logic [3:0]                  exec_alu;
    logic                        exec_src_b;
    logic                        wait_clr;
    logic                        expired;
    logic                        unused_bits;

    assign instr_w     = bus.instr;
    assign opcode      = instr_w[INSTR_WIDTH-1 -: 4];
    assign unused_bits = ^{instr_w[INSTR_WIDTH-5:0], bus.mem_rdata_valid};

    // Address generation for LOAD/STORE reuses the adder with the immediate
    assign exec_alu   = is_mem_op(opcode) ? INSTR_ADD : opcode;
    assign exec_src_b = (opcode == INSTR_ADDI) || is_mem_op(opcode);

    // Counter only runs while waiting on a handshake; cleared everywhere else
    assign wait_clr = (state_q != STATE_FETCH) && (state_q != STATE_MEM);

    alu_sequencer_mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (wait_clr),
        .ready_i  (bus.mem_ready),
        .expired_o(expired)
    );

    // Next-state, retire count and per-state control strobes
    always_comb begin
        state_d         = state_q;
        retired_d       = retired_q;
        bus.alu_control = 4'h0;
        bus.alu_src_b   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.pc_write    = 1'b0;
        bus.pc_src      = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.reg_write   = 1'b0;
        bus.wb_src      = 1'b0;
        bus.halted      = 1'b0;
        bus.fault       = 1'b0;
        unique case (state_q)
            STATE_FETCH: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = STATE_DECODE;
                end else if (expired) begin
                    state_d = STATE_FAULT;
                end
            end
            STATE_DECODE: begin
                case (opcode)
                    INSTR_HALT: state_d = STATE_HALTED;
                    INSTR_NOP:  state_d = STATE_RETIRE;
                    INSTR_JUMP: state_d = STATE_JUMP;
                    default:    state_d = STATE_EXEC;
                endcase
            end
            STATE_EXEC: begin
                bus.alu_control = exec_alu;
                bus.alu_src_b   = exec_src_b;
                state_d         = STATE_AWAIT;
            end
            STATE_AWAIT: begin
                // ALU output is registered; hold controls until the result is valid
                bus.alu_control = exec_alu;
                bus.alu_src_b   = exec_src_b;
                if (is_compare(opcode)) begin
                    state_d = STATE_BRANCH;
                end else if (is_mem_op(opcode)) begin
                    state_d = STATE_MEM;
                end else begin
                    state_d = STATE_WB;
                end
            end
            STATE_WB: begin
                bus.reg_write = 1'b1;
                state_d       = STATE_RETIRE;
            end
            STATE_BRANCH: begin
                bus.pc_write = bus.alu_flag;
                bus.pc_src   = bus.alu_flag;
                state_d      = STATE_RETIRE;
            end
            STATE_JUMP: begin
                bus.pc_write = 1'b1;
                bus.pc_src   = 1'b1;
                state_d      = STATE_RETIRE;
            end
            STATE_MEM: begin
                bus.mem_read  = (opcode == INSTR_LOAD);
                bus.mem_write = (opcode == INSTR_STORE);
                if (bus.mem_ready) begin
                    state_d = (opcode == INSTR_LOAD) ? STATE_WBMEM : STATE_RETIRE;
                end else if (expired) begin
                    state_d = STATE_FAULT;
                end
            end
            STATE_WBMEM: begin
                bus.reg_write = 1'b1;
                bus.wb_src    = 1'b1;
                state_d       = STATE_RETIRE;
            end
            STATE_RETIRE: begin
                retired_d = retired_q + 1'b1;
                state_d   = STATE_FETCH;
            end
            STATE_HALTED: bus.halted = 1'b1;
            STATE_FAULT:  bus.fault  = 1'b1;
            default:      state_d    = STATE_FETCH;
        endcase
    end

    // State and retire counter with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= STATE_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign bus.retired = retired_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench: driver pushes per-cycle expected strobes, negedge monitor compares.
module tb_alu_sequencer;

    typedef struct packed {
        logic [3:0]  alu;
        logic        srcb;
        logic        irw;
        logic        pcw;
        logic        pcs;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        wbs;
        logic        halt;
        logic        flt;
        logic [15:0] ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer_if #(.INSTR_WIDTH(16), .RETIRE_CNT_WIDTH(16)) bus ();

    alu_sequencer #(
        .INSTR_WIDTH     (16),
        .MEM_TIMEOUT     (15),
        .RETIRE_CNT_WIDTH(16)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    exp_t        exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] ret_model = 16'd0;

    // Monitor: compare every cycle for which the driver queued an expectation
    always @(negedge clk) begin
        exp_t  e;
        exp_t  a;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a.alu  = bus.alu_control;
            a.srcb = bus.alu_src_b;
            a.irw  = bus.ir_write;
            a.pcw  = bus.pc_write;
            a.pcs  = bus.pc_src;
            a.mr   = bus.mem_read;
            a.mw   = bus.mem_write;
            a.rw   = bus.reg_write;
            a.wbs  = bus.wb_src;
            a.halt = bus.halted;
            a.flt  = bus.fault;
            a.ret  = bus.retired;
            checks++;
            if (a !== e) begin
                failures++;
                $display("FAIL %s @%0t: got alu=%h srcb=%b irw=%b pcw=%b pcs=%b mr=%b mw=%b rw=%b wbs=%b halt=%b flt=%b ret=%0d; expected alu=%h srcb=%b irw=%b pcw=%b pcs=%b mr=%b mw=%b rw=%b wbs=%b halt=%b flt=%b ret=%0d",
                         t, $time, a.alu, a.srcb, a.irw, a.pcw, a.pcs, a.mr, a.mw, a.rw, a.wbs,
                         a.halt, a.flt, a.ret, e.alu, e.srcb, e.irw, e.pcw, e.pcs, e.mr, e.mw,
                         e.rw, e.wbs, e.halt, e.flt, e.ret);
            end
        end
    end

    function automatic exp_t blank();
        exp_t e;
        e = '0;
        e.ret = ret_model;
        return e;
    endfunction

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // One clock cycle: apply inputs, queue the expected outputs, advance past the edge
    task automatic step(input exp_t e, input logic rdy, input logic flg, input string tag);
        bus.mem_ready       = rdy;
        bus.mem_rdata_valid = rdy;
        bus.alu_flag        = flg;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic retire_cycle();
        step(blank(), rb(), rb(), "retire");
        ret_model = ret_model + 16'd1;
    endtask

    // Reference behaviour of one instruction, cycle by cycle, from the ISA rules
    task automatic run_word(input logic [15:0] w, input int fw, input int mw, input logic flag,
                            input bit abort_await);
        logic [3:0] op;
        exp_t       e;
        op = w[15:12];
        for (int i = 0; i < fw; i++) begin
            e = blank(); e.mr = 1'b1;
            step(e, 1'b0, rb(), "fetch_wait");
        end
        e = blank(); e.mr = 1'b1; e.irw = 1'b1; e.pcw = 1'b1;
        step(e, 1'b1, rb(), "fetch_done");
        bus.instr = w;
        step(blank(), rb(), rb(), "decode");
        if (op == 4'hF) begin
            repeat (6) begin
                e = blank(); e.halt = 1'b1;
                step(e, rb(), rb(), "halted");
            end
            return;
        end
        if (op == 4'hE) begin
            retire_cycle();
            return;
        end
        if (op == 4'hD) begin
            e = blank(); e.pcw = 1'b1; e.pcs = 1'b1;
            step(e, rb(), rb(), "jump");
            retire_cycle();
            return;
        end
        e = blank();
        e.alu  = (op == 4'hB || op == 4'hC) ? 4'h0 : op;
        e.srcb = (op == 4'h1) || (op == 4'hB) || (op == 4'hC);
        step(e, rb(), rb(), "exec");
        if (abort_await) begin
            rst_n = 1'b0;
            step(e, rb(), rb(), "await_reset");
            rst_n = 1'b1;
            ret_model = 16'd0;
            return;
        end
        step(e, rb(), rb(), "await");
        if (op >= 4'h6 && op <= 4'hA) begin
            e = blank(); e.pcw = flag; e.pcs = flag;
            step(e, rb(), flag, "branch");
        end else if (op == 4'hB || op == 4'hC) begin
            for (int i = 0; i <= mw; i++) begin
                e = blank();
                if (op == 4'hB) e.mr = 1'b1;
                else            e.mw = 1'b1;
                step(e, (i == mw), rb(), (i == mw) ? "mem_done" : "mem_wait");
            end
            if (op == 4'hB) begin
                e = blank(); e.rw = 1'b1; e.wbs = 1'b1;
                step(e, rb(), rb(), "wbmem");
            end
        end else begin
            e = blank(); e.rw = 1'b1;
            step(e, rb(), rb(), "wb");
        end
        retire_cycle();
    endtask

    // Fetch never completes: sixteen waiting cycles, then absorbing fault until reset
    task automatic fault_test();
        exp_t e;
        for (int i = 0; i < 16; i++) begin
            e = blank(); e.mr = 1'b1;
            step(e, 1'b0, rb(), "fault_wait");
        end
        repeat (4) begin
            e = blank(); e.flt = 1'b1;
            step(e, rb(), rb(), "fault_hold");
        end
        rst_n = 1'b0;
        e = blank(); e.flt = 1'b1;
        step(e, rb(), rb(), "fault_reset");
        rst_n = 1'b1;
        ret_model = 16'd0;
    endtask

    initial begin
        logic [15:0] w;
        int          fw;
        int          mw;
        bus.instr           = 16'h0000;
        bus.mem_ready       = 1'b0;
        bus.mem_rdata_valid = 1'b0;
        bus.alu_flag        = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_word(16'h3312, 0, 0, 1'b0, 1'b0);
        run_word(16'hA012, 0, 0, 1'b1, 1'b0);
        run_word(16'hA012, 0, 0, 1'b0, 1'b0);
        run_word(16'hB120, 0, 3, 1'b0, 1'b0);
        run_word(16'hC345, 15, 15, 1'b0, 1'b0);
        run_word(16'hB678, 15, 0, 1'b0, 1'b0);
        run_word(16'hD00F, 2, 0, 1'b0, 1'b0);
        run_word(16'hE000, 0, 0, 1'b0, 1'b0);
        run_word(16'h1234, 1, 0, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            w = 16'($urandom);
            w[15:12] = 4'($urandom_range(0, 14));
            fw = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            mw = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            run_word(w, fw, mw, rb(), 1'b0);
        end

        run_word(16'h2123, 1, 0, 1'b0, 1'b1);
        run_word(16'hE000, 0, 0, 1'b0, 1'b0);
        fault_test();
        run_word(16'h0456, 0, 0, 1'b0, 1'b0);
        run_word(16'hF000, 0, 0, 1'b0, 1'b0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
